// File: rtl/ring_osc_gen.sv
// ring_osc_gen: twisted-ring oscillator with a programmable per-stage delay.
// The edge-count measurement unit is compiled only when RING_OSC_MEAS_EN is defined.
module ring_osc_gen #(
  parameter int STAGES = 5,
  parameter int DLY_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DLY_W-1:0] dly,
  output logic             out1,
  input  logic             start,
  input  logic [CNT_W-1:0] gate_len,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] edge_cnt
);

  logic [STAGES-1:0] ring_r;
  logic [DLY_W-1:0]  dcnt_r;
  logic [DLY_W-1:0]  dlat_r;
  logic [DLY_W-1:0]  dly_eff_s;
  logic [DLY_W-1:0]  dcur_s;
  logic              step_s;

  // Step delay: a fresh dly value applies at the start of a step, the latched one mid-step
  always_comb begin
    if (dly == {DLY_W{1'b0}}) begin
      dly_eff_s = DLY_W'(1'b1);
    end else begin
      dly_eff_s = dly;
    end
    if (dcnt_r == {DLY_W{1'b0}}) begin
      dcur_s = dly_eff_s;
    end else begin
      dcur_s = dlat_r;
    end
    step_s = en && (dcnt_r == (dcur_s - DLY_W'(1'b1)));
  end

  // Ring and delay counter; a low en freezes the ring and restarts the step timer
  always_ff @(posedge clk) begin
    if (rst) begin
      ring_r <= {STAGES{1'b0}};
      dcnt_r <= {DLY_W{1'b0}};
      dlat_r <= {DLY_W{1'b0}};
    end else if (!en) begin
      dcnt_r <= {DLY_W{1'b0}};
    end else begin
      if (dcnt_r == {DLY_W{1'b0}}) begin
        dlat_r <= dly_eff_s;
      end else begin
        dlat_r <= dlat_r;
      end
      if (step_s) begin
        ring_r <= {ring_r[STAGES-2:0], ~ring_r[STAGES-1]};
        dcnt_r <= {DLY_W{1'b0}};
      end else begin
        dcnt_r <= dcnt_r + DLY_W'(1'b1);
      end
    end
  end

  assign out1 = ring_r[STAGES-1];

`ifdef RING_OSC_MEAS_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEAS = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] win_r;
  logic [CNT_W-1:0] win_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             prev_r;
  logic             busy_r;
  logic             done_r;
  logic             rise_s;

  assign rise_s = out1 & ~prev_r;

  // Measurement next-state: window countdown and saturating rising-edge count
  always_comb begin
    state_nxt_s = state_r;
    win_nxt_s   = win_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          cnt_nxt_s = {CNT_W{1'b0}};
          win_nxt_s = gate_len;
          if (gate_len == {CNT_W{1'b0}}) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = MEAS;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MEAS: begin
        win_nxt_s = win_r - CNT_W'(1'b1);
        if (rise_s && (cnt_r != {CNT_W{1'b1}})) begin
          cnt_nxt_s = cnt_r + CNT_W'(1'b1);
        end else begin
          cnt_nxt_s = cnt_r;
        end
        if (win_r == CNT_W'(1'b1)) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = MEAS;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Measurement state, counters and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      win_r   <= {CNT_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      prev_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      win_r   <= win_nxt_s;
      cnt_r   <= cnt_nxt_s;
      prev_r  <= out1;
      busy_r  <= (state_nxt_s == MEAS);
      done_r  <= (state_nxt_s == DONE);
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign edge_cnt = cnt_r;
`else
  logic unused_s;

  assign unused_s = ^{start, gate_len};
  assign busy     = 1'b0;
  assign done     = 1'b0;
  assign edge_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_ring_osc_gen.sv
// Self-checking bench for ring_osc_gen: per-cycle model comparison plus directed timing checks.
// Measurement checks are exercised when RING_OSC_MEAS_EN is defined; otherwise tied-off outputs are checked.
`timescale 1ns/1ps
module tb_ring_osc_gen;
  localparam int STAGES = 5;
  localparam int DLY_W  = 4;
  localparam int CNT_W  = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             start = 1'b0;
  logic [DLY_W-1:0] dly = '0;
  logic [CNT_W-1:0] gate_len = '0;
  logic             out1;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] edge_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  ring_osc_gen #(.STAGES(STAGES), .DLY_W(DLY_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .dly(dly), .out1(out1), .start(start),
    .gate_len(gate_len), .busy(busy), .done(done), .edge_cnt(edge_cnt)
  );

  // Model: out1 follows from the number of ring steps taken; each step lasts D cycles of en=1
  int     m_steps = 0;
  int     m_wait  = 0;
  int     m_d     = 1;
  bit     m_prev  = 1'b0;
  bit     m_busy  = 1'b0;
  bit     m_done  = 1'b0;
  int     m_left  = 0;
  longint m_cnt   = 0;

  function automatic bit model_out1();
    return (m_steps % (2 * STAGES)) >= STAGES;
  endfunction

  task automatic model_step();
    bit o;
    o = model_out1();
    if (rst) begin
      m_steps = 0; m_wait = 0; m_prev = 1'b0;
      m_busy = 1'b0; m_done = 1'b0; m_left = 0; m_cnt = 0;
    end else begin
`ifdef RING_OSC_MEAS_EN
      if (m_busy) begin
        m_left--;
        if (o && !m_prev && m_cnt < (longint'(1) << CNT_W) - 1) m_cnt++;
        if (m_left == 0) begin m_busy = 1'b0; m_done = 1'b1; end
      end else if (m_done) begin
        m_done = 1'b0;
      end else if (start) begin
        m_cnt = 0;
        if (gate_len == 0) m_done = 1'b1;
        else begin m_busy = 1'b1; m_left = int'(gate_len); end
      end
`endif
      m_prev = o;
      if (!en) begin
        m_wait = 0;
      end else begin
        if (m_wait == 0) m_d = (dly == 0) ? 1 : int'(dly);
        m_wait++;
        if (m_wait == m_d) begin m_steps++; m_wait = 0; end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      check("model_out1", out1, model_out1());
      check("model_busy", busy, m_busy);
      check("model_done", done, m_done);
      check("model_edge_cnt", edge_cnt, m_cnt);
    end
  end

  // Counts clock cycles until out1 reaches lvl; returns max+1 when it never does
  task automatic wait_out1(input bit lvl, input int max, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end while (out1 !== lvl && cyc <= max);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; start = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  int c, c2, c3, busy_n, done_n;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_on = 1'b1;
    check("rst_out1", out1, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_edge_cnt", edge_cnt, 0);

    // dly=2: rise 10 cycles after en, fall 10 later, period 20
    @(posedge clk);
    #1 rst = 1'b0; en = 1'b1; dly = 4'd2;
    wait_out1(1'b1, 100, c);  check("d2_rise", c, 10);
    wait_out1(1'b0, 100, c);  check("d2_fall", c, 10);
    wait_out1(1'b1, 100, c2);
    wait_out1(1'b0, 100, c3); check("d2_period", c2 + c3, 20);

    // dly=0 behaves as dly=1: period 10
    @(negedge clk);
    do_reset(); en = 1'b1; dly = 4'd0;
    wait_out1(1'b1, 100, c);  check("d0_rise", c, 5);
    wait_out1(1'b0, 100, c2);
    wait_out1(1'b1, 100, c3); check("d0_period", c2 + c3, 10);
    @(negedge clk);
    do_reset(); en = 1'b1; dly = 4'd1;
    wait_out1(1'b1, 100, c);  check("d1_rise", c, 5);
    wait_out1(1'b0, 100, c2);
    wait_out1(1'b1, 100, c3); check("d1_period", c2 + c3, 10);

    // dly changed at arbitrary points mid-step; the per-cycle model checks the ring
    for (int i = 0; i < 6; i++) begin
      repeat (7) @(negedge clk);
      dly = DLY_W'((i * 5) % 4);
    end
    repeat (20) @(negedge clk);

    // en dropped for 7 cycles on a step boundary during the high half-period
    do_reset(); en = 1'b1; dly = 4'd2;
    wait_out1(1'b1, 100, c);  check("frz_rise", c, 10);
    repeat (4) @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); @(negedge clk);
      check("frz_hold", out1, 1);
    end
    en = 1'b1;
    wait_out1(1'b0, 50, c);   check("frz_resume", c, 6);

`ifdef RING_OSC_MEAS_EN
    // 100-cycle window from reset, start ignored mid-window
    @(negedge clk);
    do_reset(); en = 1'b1; dly = 4'd2; start = 1'b1; gate_len = 16'd100;
    @(posedge clk);
    #1 start = 1'b0;
    busy_n = 0; done_n = 0;
    for (int i = 0; i < 110; i++) begin
      @(negedge clk);
      busy_n += int'(busy); done_n += int'(done);
      if (i == 50) begin start = 1'b1; gate_len = 16'd7; end
      else start = 1'b0;
    end
    check("meas_busy_cycles", busy_n, 100);
    check("meas_done_pulses", done_n, 1);
    check("meas_edge_cnt", edge_cnt, 5);

    // zero-length window: done the next cycle, count cleared, never busy
    start = 1'b1; gate_len = 16'd0;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("gl0_done", done, 1);
    check("gl0_busy", busy, 0);
    check("gl0_edge_cnt", edge_cnt, 0);
    @(negedge clk);
    check("gl0_done_end", done, 0);

    // reset mid-window aborts without a done pulse
    do_reset(); en = 1'b1; dly = 4'd2; start = 1'b1; gate_len = 16'd100;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("abort_pre_cnt", edge_cnt, 2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_edge_cnt", edge_cnt, 0);
    check("abort_out1", out1, 0);
    check("abort_done", done, 0);
    rst = 1'b0;
    done_n = 0;
    repeat (120) begin @(negedge clk); done_n += int'(done); end
    check("abort_no_done", done_n, 0);
`else
    // measurement unit absent: status outputs stay tied low despite start
    @(negedge clk);
    do_reset(); en = 1'b1; dly = 4'd2; start = 1'b1; gate_len = 16'd5;
    @(posedge clk);
    #1 start = 1'b0;
    busy_n = 0; done_n = 0;
    repeat (30) begin @(negedge clk); busy_n += int'(busy); done_n += int'(done); end
    check("nomeas_busy", busy_n, 0);
    check("nomeas_done", done_n, 0);
    check("nomeas_edge_cnt", edge_cnt, 0);
`endif

    @(negedge clk);
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ring_osc_gen.md
RING_OSC_GEN -- requirements
Module: ring_osc_gen

Interface
REQ-001 SHALL provide parameter STAGES, default 5, giving the number of ring stages; legal values are odd and 3..63.
REQ-002 SHALL provide parameter DLY_W, default 4, giving the width of the per-stage delay input.
REQ-003 SHALL provide parameter CNT_W, default 16, giving the width of the gate-length input and the edge-count output.
REQ-004 SHALL have one clock and a synchronous, active-high reset, with ports in this order: clk (input, 1 bit, rising-edge clock) and rst (input, 1 bit, synchronous active-high reset).
REQ-005 SHALL have port en (input, 1 bit): ring runs while high.
REQ-006 SHALL have port dly (input, DLY_W bits): clock cycles per stage step; a value of 0 is treated as 1.
REQ-007 SHALL have port out1 (output, 1 bit): oscillator output, equal to the last ring stage.
REQ-008 SHALL have port start (input, 1 bit): single-cycle pulse that begins a measurement.
REQ-009 SHALL have port gate_len (input, CNT_W bits): measurement window length in cycles.
REQ-010 SHALL have port busy (output, 1 bit): high while a measurement is in progress.
REQ-011 SHALL have port done (output, 1 bit): one-cycle pulse when a measurement ends.
REQ-012 SHALL have port edge_cnt (output, CNT_W bits): number of out1 rising edges counted in the last window.

Function
REQ-013 SHALL hold ring state r[STAGES-1:0] and drive out1 = r[STAGES-1].
REQ-014 SHALL advance the ring by one step as r <= {r[STAGES-2:0], ~r[STAGES-1]}; this twisted ring has a period of 2*STAGES steps.
REQ-015 SHALL run delay counter dcnt from 0 to D-1, where D = max(dly,1); a step occurs in the cycle where en=1 and dcnt==D-1, and dcnt then returns to 0.
REQ-016 SHALL sample dly only when dcnt==0, so that a change made mid-step takes effect on the following step.
REQ-017 SHALL, while en=0, hold r frozen and force dcnt to 0; when en rises again, operation resumes from the held r.
REQ-018 SHALL produce an out1 period of exactly 2*STAGES*D cycles while en=1 and dly is constant.
REQ-019 SHALL implement the measurement FSM with states IDLE, MEAS and DONE.
REQ-020 SHALL, in IDLE with start=1: load the window counter with gate_len, clear edge_cnt, and go to MEAS; if gate_len==0, go directly to DONE instead.
REQ-021 SHALL, in MEAS, decrement the window counter every cycle and add 1 to edge_cnt on each out1 rising edge (detected against out1 registered one cycle earlier); edge_cnt saturates at all-ones.
REQ-022 SHALL transition MEAS -> DONE in the cycle the window counter reaches 0, counting any rising edge that occurs in that same final cycle.
REQ-023 SHALL spend exactly one cycle in DONE, assert done during it, and return to IDLE.
REQ-024 SHALL assert busy exactly in MEAS.
REQ-025 SHALL ignore start while in MEAS or DONE.
REQ-026 SHALL hold edge_cnt stable from DONE until the next accepted start.
REQ-027 SHALL keep the measurement running when en falls during MEAS, counting no further edges while the ring is frozen.

Reset
REQ-028 SHALL, when rst=1 at a clock edge, set r=0, dcnt=0, FSM=IDLE, window counter=0, edge_cnt=0, busy=0, done=0 and out1=0.
REQ-029 SHALL abort any measurement in progress when rst is asserted mid-window, without pulsing done.
REQ-030 SHALL give rst priority over en and start in the same cycle.

Configuration
REQ-031 SHALL compile the measurement unit (FSM, window counter, edge counter) only when macro RING_OSC_MEAS_EN is defined.
REQ-032 SHALL, without RING_OSC_MEAS_EN, still declare all ports, tie busy=0, done=0 and edge_cnt=0, ignore start and gate_len, and leave ring behaviour unchanged.

Verification
REQ-033 SHALL verify: STAGES=5, dly=2, en=1 from reset release -> out1 rises 10 cycles after en rises, falls 10 cycles later, and has a period of 20 cycles.
REQ-034 SHALL verify: dly=0, STAGES=5 -> out1 period of 10 cycles, identical to dly=1.
REQ-035 SHALL verify: STAGES=5, dly=2, start and en asserted in the same cycle after reset, gate_len=100 -> busy high for 100 cycles, done pulses once, edge_cnt=5.
REQ-036 SHALL verify: gate_len=0 with start -> done pulses the next cycle, edge_cnt=0, busy never asserted.
REQ-037 SHALL verify: rst asserted mid-window -> busy=0, edge_cnt=0 and out1=0 the next cycle, with no done pulse.
REQ-038 SHALL verify: en dropped for 7 cycles mid-run -> out1 holds its level, and the remaining half-period resumes exactly where it was frozen.
